// File: rtl/pir_pkg.sv
// Shared types and constants for the PIR zone scheduler: state encoding,
// log entry layout and the round-robin zone picker.
package pir_pkg;

    typedef enum logic [3:0] {
        S_DISARMED = 4'b0001,
        S_IDLE     = 4'b0010,
        S_ALARM    = 4'b0100,
        S_COOLDOWN = 4'b1000
    } state_e;

    localparam int ZONE_COUNT = 3;
    localparam int LOG_DEPTH  = 8;
    localparam int LOG_AW     = 3;
    localparam int ZONE_ID_W  = 2;
    localparam int SEQ_W      = 6;
    localparam int ENTRY_W    = ZONE_ID_W + SEQ_W;

    // Zone ID 0 means "no alarm"; zones 0..2 report as 1..3.
    localparam logic [ZONE_ID_W-1:0] ZONE_ID_NONE = '0;

    typedef struct packed {
        logic       found;
        logic [1:0] zone;
    } rr_pick_t;

    function automatic logic [ZONE_ID_W-1:0] zone_id(input logic [1:0] zone);
        return zone + 2'd1;
    endfunction

    function automatic rr_pick_t rr_pick(input logic [ZONE_COUNT-1:0] pend,
                                         input logic [1:0]            last);
        rr_pick_t   r;
        logic [1:0] cand;
        r.found = 1'b0;
        r.zone  = '0;
        cand    = last;
        for (int i = 0; i < ZONE_COUNT; i++) begin
            cand = (cand == 2'(ZONE_COUNT - 1)) ? 2'd0 : cand + 2'd1;
            if (!r.found && pend[cand]) begin
                r.found = 1'b1;
                r.zone  = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pir_debounce.sv
// One zone's debounce counter; pulses rise_o on the cycle the count of
// consecutive high samples reaches DEBOUNCE_CYCLES.
module pir_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic sensor_i,
    output logic rise_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !sensor_i) begin
            cnt_d = '0;
        end else if (cnt_q != 4'(DEBOUNCE_CYCLES)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Saturation means a held sensor fires once; it must drop low to re-arm.
    assign rise_o = sensor_i && !clr_i && (cnt_q == 4'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pir_zone_scheduler.sv
// Shares one buzzer/LED alarm among three debounced PIR zones in round-robin
// order and records each grant in an 8-entry circular event log.
//   state    | meaning
//   DISARMED | outputs off, pending and debounce held clear
//   IDLE     | waiting for a pending zone
//   ALARM    | buzzer on for the granted zone
//   COOLDOWN | one-cycle quiet gap before the next grant
module pir_zone_scheduler
    import pir_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ALARM_CYCLES    = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  stop_alarm,
    input  logic [ZONE_COUNT-1:0] pir_sensor,
    output logic                  buzzer,
    output logic [ZONE_COUNT-1:0] zone_led,
    output logic [ZONE_ID_W-1:0]  active_zone,
    input  logic [LOG_AW-1:0]     log_rd_addr,
    output logic [ENTRY_W-1:0]    log_rd_data,
    output logic [3:0]            log_count,
    output logic                  log_overflow
);

    state_e                state_q, state_d;
    logic [ZONE_COUNT-1:0] pend_q, pend_d, rise;
    logic [1:0]            last_q, last_d, grant_q, grant_d;
    logic [6:0]            cyc_q, cyc_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic                  buzzer_q, buzzer_d;
    logic [ZONE_COUNT-1:0] led_q, led_d;
    logic [ZONE_ID_W-1:0]  az_q, az_d;
    logic                  deb_clr;
    rr_pick_t              pick;

    logic [ENTRY_W-1:0]    log_mem_q [LOG_DEPTH];
    logic [LOG_AW-1:0]     wr_ptr_q, rd_idx;
    logic [3:0]            cnt_q;
    logic                  ovf_q;
    logic [ENTRY_W-1:0]    rd_q;
    logic                  log_we;
    logic [ENTRY_W-1:0]    log_wdata;

    assign deb_clr = (state_q == S_DISARMED) || !arm;

    for (genvar z = 0; z < ZONE_COUNT; z++) begin : g_deb
        pir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (deb_clr),
            .sensor_i (pir_sensor[z]),
            .rise_o   (rise[z])
        );
    end

    always_comb begin
        pick      = rr_pick(pend_q, last_q);
        state_d   = state_q;
        pend_d    = pend_q;
        last_d    = last_q;
        grant_d   = grant_q;
        cyc_d     = cyc_q;
        seq_d     = seq_q;
        log_we    = 1'b0;
        log_wdata = {zone_id(pick.zone), seq_q};

        case (state_q)
            S_DISARMED: begin
                if (arm) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!arm) begin
                    state_d = S_DISARMED;
                end else if (pick.found) begin
                    state_d            = S_ALARM;
                    pend_d[pick.zone]  = 1'b0;
                    last_d             = pick.zone;
                    grant_d            = pick.zone;
                    cyc_d              = '0;
                    log_we             = 1'b1;
                    seq_d              = seq_q + 6'd1;
                end
            end
            S_ALARM: begin
                if (!arm) begin
                    state_d = S_DISARMED;
                end else if (stop_alarm || cyc_q == 7'(ALARM_CYCLES - 1)) begin
                    state_d = S_COOLDOWN;
                end else begin
                    cyc_d = cyc_q + 7'd1;
                end
            end
            S_COOLDOWN: state_d = S_IDLE;
            default:    state_d = S_DISARMED;
        endcase

        // New detections are OR'd in after the grant clear so a same-cycle set wins.
        pend_d = pend_d | (rise & {ZONE_COUNT{arm}});
        if (state_q == S_DISARMED || !arm) pend_d = '0;

        buzzer_d = (state_d == S_ALARM);
        led_d    = buzzer_d ? (3'b001 << grant_d) : '0;
        az_d     = buzzer_d ? zone_id(grant_d) : ZONE_ID_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_DISARMED;
            pend_q   <= '0;
            last_q   <= 2'd2;
            grant_q  <= '0;
            cyc_q    <= '0;
            seq_q    <= '0;
            buzzer_q <= 1'b0;
            led_q    <= '0;
            az_q     <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            cyc_q    <= cyc_d;
            seq_q    <= seq_d;
            buzzer_q <= buzzer_d;
            led_q    <= led_d;
            az_q     <= az_d;
        end
    end

    // Address 0 is the newest entry, i.e. the slot just behind the write pointer.
    assign rd_idx = wr_ptr_q - 3'd1 - log_rd_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LOG_DEPTH; i++) log_mem_q[i] <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            rd_q <= ({1'b0, log_rd_addr} < cnt_q) ? log_mem_q[rd_idx] : '0;
            if (log_we) begin
                log_mem_q[wr_ptr_q] <= log_wdata;
                wr_ptr_q            <= wr_ptr_q + 3'd1;
                if (cnt_q == 4'(LOG_DEPTH)) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    assign buzzer       = buzzer_q;
    assign zone_led     = led_q;
    assign active_zone  = az_q;
    assign log_rd_data  = rd_q;
    assign log_count    = cnt_q;
    assign log_overflow = ovf_q;

endmodule

// File: tb/tb_pir_zone_scheduler.sv
// Bench for pir_zone_scheduler: alarm scoreboard monitor, table-driven log
// reads and hand-timed sequences for stop, disarm, glitch and overflow cases.
module tb_pir_zone_scheduler;

    localparam int DEB = 4;
    localparam int ALM = 8;

    logic       clk = 1'b0;
    logic       rst_n, arm, stop_alarm;
    logic [2:0] pir_sensor;
    logic       buzzer;
    logic [2:0] zone_led;
    logic [1:0] active_zone;
    logic [2:0] log_rd_addr;
    logic [7:0] log_rd_data;
    logic [3:0] log_count;
    logic       log_overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int zone;
        int dur;
        int gap;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int         grp;
        logic [2:0] addr;
        logic [7:0] data;
    } rd_vec_t;
    rd_vec_t rd_tbl[14];

    always #5 clk = ~clk;

    pir_zone_scheduler #(.DEBOUNCE_CYCLES(DEB), .ALARM_CYCLES(ALM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .stop_alarm   (stop_alarm),
        .pir_sensor   (pir_sensor),
        .buzzer       (buzzer),
        .zone_led     (zone_led),
        .active_zone  (active_zone),
        .log_rd_addr  (log_rd_addr),
        .log_rd_data  (log_rd_data),
        .log_count    (log_count),
        .log_overflow (log_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int z, input int d, input int g);
        exp_t e;
        e.zone = z;
        e.dur  = d;
        e.gap  = g;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        arm         = 1'b0;
        stop_alarm  = 1'b0;
        pir_sensor  = '0;
        log_rd_addr = '0;
        tick(2);
        check("rst_buzzer", buzzer, 0);
        check("rst_zone_led", zone_led, 0);
        check("rst_active_zone", active_zone, 0);
        check("rst_log_rd_data", log_rd_data, 0);
        check("rst_log_count", log_count, 0);
        check("rst_log_overflow", log_overflow, 0);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic read_grp(input int g);
        foreach (rd_tbl[i]) begin
            if (rd_tbl[i].grp == g) begin
                log_rd_addr = rd_tbl[i].addr;
                tick(1);
                check($sformatf("log_rd_g%0d_a%0d", g, rd_tbl[i].addr), log_rd_data, rd_tbl[i].data);
            end
        end
    endtask

    // Alarm monitor: each buzzer rise must match the next expected grant.
    bit   prev_buz = 1'b0;
    bit   have_cur = 1'b0;
    int   hi_cnt   = 0;
    int   lo_cnt   = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (buzzer === 1'b1 && !prev_buz) begin
            check("sb_expected_alarm", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                cur      = sb_q.pop_front();
                have_cur = 1'b1;
                check("sb_active_zone", active_zone, cur.zone + 1);
                check("sb_zone_led", zone_led, 1 << cur.zone);
                if (cur.gap != 0) check("sb_gap", lo_cnt, cur.gap);
            end
            hi_cnt = 1;
        end else if (buzzer === 1'b1) begin
            hi_cnt++;
        end else if (prev_buz) begin
            if (have_cur) check("sb_duration", hi_cnt, cur.dur);
            have_cur = 1'b0;
            lo_cnt   = 1;
        end else begin
            lo_cnt++;
        end
        prev_buz = (buzzer === 1'b1);
    end

    initial begin
        rd_tbl[0]  = '{2, 3'd0, 8'hC2};
        rd_tbl[1]  = '{2, 3'd1, 8'h81};
        rd_tbl[2]  = '{2, 3'd2, 8'h40};
        rd_tbl[3]  = '{2, 3'd3, 8'h00};
        rd_tbl[4]  = '{2, 3'd7, 8'h00};
        rd_tbl[5]  = '{6, 3'd0, 8'hC8};
        rd_tbl[6]  = '{6, 3'd1, 8'h87};
        rd_tbl[7]  = '{6, 3'd2, 8'h46};
        rd_tbl[8]  = '{6, 3'd3, 8'hC5};
        rd_tbl[9]  = '{6, 3'd4, 8'h84};
        rd_tbl[10] = '{6, 3'd5, 8'h43};
        rd_tbl[11] = '{6, 3'd6, 8'hC2};
        rd_tbl[12] = '{6, 3'd7, 8'h81};
        rd_tbl[13] = '{6, 3'd0, 8'hC8};

        // Single zone: grant latency, pre-write read, full alarm length.
        do_reset();
        arm = 1'b1;
        tick(1);
        log_rd_addr = 3'd0;
        pir_sensor  = 3'b001;
        push(0, ALM, 0);
        tick(DEB);
        check("s1_buzzer_before_grant", buzzer, 0);
        tick(1);
        check("s1_buzzer_at_grant", buzzer, 1);
        check("s1_active_zone", active_zone, 1);
        check("s1_zone_led", zone_led, 3'b001);
        check("s1_rd_during_write", log_rd_data, 8'h00);
        check("s1_log_count", log_count, 1);
        tick(1);
        check("s1_rd_after_write", log_rd_data, 8'h40);
        tick(4);
        pir_sensor = '0;
        tick(8);
        check("s1_buzzer_done", buzzer, 0);

        // All three zones at once: round-robin order with 2-cycle gaps.
        do_reset();
        arm = 1'b1;
        tick(1);
        pir_sensor = 3'b111;
        push(0, ALM, 0);
        push(1, ALM, 2);
        push(2, ALM, 2);
        tick(6);
        pir_sensor = '0;
        tick(40);
        check("s2_log_count", log_count, 3);
        check("s2_log_overflow", log_overflow, 0);
        read_grp(2);

        // Operator stop three cycles into an alarm; queued zone follows.
        do_reset();
        arm = 1'b1;
        tick(1);
        pir_sensor = 3'b011;
        push(0, 3, 0);
        push(1, ALM, 2);
        tick(5);
        check("s3_alarm_zone0", active_zone, 1);
        pir_sensor = '0;
        tick(2);
        stop_alarm = 1'b1;
        tick(1);
        check("s3_stop_buzzer", buzzer, 0);
        check("s3_stop_active_zone", active_zone, 0);
        check("s3_stop_zone_led", zone_led, 0);
        stop_alarm = 1'b0;
        tick(1);
        check("s3_cooldown_buzzer", buzzer, 0);
        tick(1);
        check("s3_next_buzzer", buzzer, 1);
        check("s3_next_active_zone", active_zone, 2);
        check("s3_next_zone_led", zone_led, 3'b010);
        tick(12);
        check("s3_log_count", log_count, 2);

        // Short glitches never create an alarm, armed or across re-arm.
        do_reset();
        arm = 1'b1;
        tick(1);
        pir_sensor = 3'b001;
        tick(DEB - 1);
        pir_sensor = '0;
        tick(10);
        check("s4_glitch_log_count", log_count, 0);
        arm = 1'b0;
        tick(2);
        pir_sensor = 3'b001;
        tick(3);
        arm = 1'b1;
        tick(DEB);
        pir_sensor = '0;
        tick(10);
        check("s4_rearm_log_count", log_count, 0);
        check("s4_rearm_buzzer", buzzer, 0);

        // Disarm mid-alarm drops outputs and pending, keeps the log.
        do_reset();
        arm = 1'b1;
        tick(1);
        pir_sensor = 3'b001;
        push(0, 5, 0);
        tick(5);
        check("s5_alarm_on", buzzer, 1);
        pir_sensor = 3'b010;
        tick(4);
        arm = 1'b0;
        tick(1);
        check("s5_disarm_buzzer", buzzer, 0);
        check("s5_disarm_zone_led", zone_led, 0);
        check("s5_disarm_active_zone", active_zone, 0);
        pir_sensor = '0;
        tick(2);
        arm = 1'b1;
        tick(15);
        check("s5_no_stale_alarm", buzzer, 0);
        check("s5_log_count", log_count, 1);
        log_rd_addr = 3'd0;
        tick(1);
        check("s5_log_retained", log_rd_data, 8'h40);

        // Nine events wrap the log and set the sticky overflow.
        do_reset();
        arm = 1'b1;
        tick(1);
        for (int i = 0; i < 9; i++) begin
            pir_sensor = 3'b001 << (i % 3);
            push(i % 3, ALM, 0);
            tick(5);
            pir_sensor = '0;
            tick(12);
            if (i == 7) begin
                check("s6_count_at_8", log_count, 8);
                check("s6_ovf_at_8", log_overflow, 0);
            end
        end
        check("s6_count_after_9", log_count, 8);
        check("s6_ovf_after_9", log_overflow, 1);
        read_grp(6);

        // Reset in the middle of an alarm forces reset values at that edge.
        pir_sensor = 3'b010;
        push(1, 3, 0);
        tick(5);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("s7_rst_buzzer", buzzer, 0);
        check("s7_rst_active_zone", active_zone, 0);
        check("s7_rst_log_count", log_count, 0);
        check("s7_rst_log_overflow", log_overflow, 0);
        rst_n      = 1'b1;
        pir_sensor = '0;
        tick(3);

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pir_zone_scheduler.md
# pir_zone_scheduler

Controller that shares one alarm resource (buzzer plus zone indicator LEDs) among three PIR motion zones. It sits between the raw PIR sensor inputs and the alarm outputs. Each zone is debounced, detections are queued as pending requests, and pending zones are granted the alarm one at a time in round-robin order. Every granted event is recorded in an 8-entry circular event log that the display logic can read.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive high samples required to accept a detection (1..15).
- ALARM_CYCLES, 100: buzzer on-time per granted event, in clock cycles (2..127).
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset: one clock; synchronous, active-low.
- arm  in  1  1 = system armed, 0 = disarmed.
- stop_alarm  in  1  operator acknowledge; ends the current alarm early.
- pir_sensor  in  3  raw sensor levels; bit i = zone i.
- buzzer  out  1  shared alarm drive.
- zone_led  out  3  one-hot LED for the zone currently alarming.
- active_zone  out  2  zone ID of the current alarm (1..3); 0 when no alarm.
- log_rd_addr  in  3  log index; 0 = newest entry.
- log_rd_data  out  8  registered log read data, entry = {zone_id[1:0], seq[5:0]}.
- log_count  out  4  valid log entries, saturating at 8.
- log_overflow  out  1  sticky; set when an entry overwrites the oldest entry.

## Operation
- Reset values: buzzer=0, zone_led=0, active_zone=0, log_rd_data=0, log_count=0, log_overflow=0. State=DISARMED. Pending bits, debounce counters, round-robin pointer (last served = zone 2), seq counter and all log entries are cleared to 0.
- Debounce, per zone: the counter increments while the sensor is 1 and clears to 0 when it is 0. The counter saturates at DEBOUNCE_CYCLES. The pending bit is set on the cycle the counter reaches DEBOUNCE_CYCLES and arm=1. To re-trigger, the sensor must be sampled 0 at least once.
- A detection on a zone whose pending bit is already set merges into it. No extra event is created.
- If a pending bit is set and cleared for the same zone in the same cycle, the set wins.
- State DISARMED: all outputs low, pending bits and debounce counters held at 0. arm=1 moves to IDLE.
- State IDLE: arm=0 moves to DISARMED. Otherwise, if any pending bit is set:
  - grant the first pending zone searching from last_served+1, wrapping 2→0;
  - clear that zone's pending bit and update last_served;
  - write the log entry {zone+1, seq}, then increment seq (mod 64);
  - move to ALARM.
- State ALARM: buzzer=1, zone_led[g]=1, active_zone=g+1; the cycle counter increments.
  - arm=0 moves to DISARMED (highest priority).
  - Otherwise stop_alarm=1, or counter==ALARM_CYCLES-1, moves to COOLDOWN.
  - Pending bits keep accumulating during ALARM.
- State COOLDOWN: buzzer, zone_led and active_zone go to 0; unconditionally moves to IDLE.
- Log: 8-entry circular buffer.
  - When a write happens with log_count==8, the oldest entry is overwritten and log_overflow is set.
  - The log and log_overflow survive disarm; only rst_n clears them.
- Log reads at log_rd_addr >= log_count return 8'h00.
- State encoding is one-hot, 4 bits: DISARMED=0001, IDLE=0010, ALARM=0100, COOLDOWN=1000.

## Timing
- Outputs are registered and change on the same edge that enters a state.
- Sensor rise sampled at edge t: pending is set at edge t+DEBOUNCE_CYCLES-1, and the grant (buzzer=1) happens at edge t+DEBOUNCE_CYCLES if the state is IDLE.
- Buzzer high for exactly ALARM_CYCLES cycles when not stopped.
- stop_alarm sampled 1 at edge e clears the buzzer at edge e.
- The minimum buzzer-low gap between consecutive alarms is 2 cycles (COOLDOWN, then IDLE).
- log_rd_data has 1-cycle read latency. A read in the cycle of a write returns the pre-write contents.
- rst_n low at any edge, including mid-alarm, forces the reset values at that edge.

## Structure
- Package pir_pkg holds:
  - state encodings;
  - ZONE_COUNT=3;
  - LOG_DEPTH=8;
  - log entry field widths and the zone ID mapping (0 = none, 1..3 = zones).
- Sub-module pir_debounce holds one zone's counter and rising-detect pulse. It is instantiated three times.
- The round-robin select, FSM and log stay in the top module.

## Test plan
- arm=1, pir_sensor=3'b001 held for 10 cycles (DEBOUNCE_CYCLES=4, ALARM_CYCLES=8) -> buzzer high for 8 cycles, zone_led=001, active_zone=1, log entry 0 = 8'h40, log_count=1.
- pir_sensor=3'b111 in one cycle -> alarms served zone0, zone1, zone2 in that order, each separated by a 2-cycle buzzer-low gap. Log newest-first = 8'hC2, 8'h81, 8'h40.
- stop_alarm pulsed 3 cycles into an alarm -> buzzer low at that edge, COOLDOWN, then IDLE. A queued pending zone is granted 2 cycles later.
- 3-cycle sensor glitch -> no pending bit, no alarm. The same glitch with arm=0 followed by arm=1 -> no alarm.
- arm=0 mid-alarm -> buzzer=0 and zone_led=0 at that edge, pending bits cleared, log retained.
- 9 events -> log_count=8, log_overflow=1, entry 7 = second event, entry 0 = ninth event (seq=8).
